// File: rtl/maxpool_pkg.sv
// Shared types and default sizing for the max-pooling stage.
package maxpool_pkg;

  // Sequencer states for maxpool3_stage
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_RD = 3'd1,
    CMP     = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_NUM_OUT    = 169;

endpackage : maxpool_pkg

// File: rtl/max3_signed.sv
// Combinational signed maximum of three values.
// On equal values the lowest-numbered input is selected.
module max3_signed
  import maxpool_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  output logic signed [W-1:0] y
);

  logic signed [W-1:0] ab;

  // Strict greater-than keeps the earlier input on ties
  always_comb begin
    ab = a;
    y  = a;
    if (b > a) ab = b;
    y = ab;
    if (c > ab) y = c;
  end

endmodule : max3_signed

// File: rtl/maxpool3_stage.sv
// Max-pooling stage: reads three signed convolution results per step,
// writes their maximum to the pooled-result memory and steps the
// triplet counter.
// Build option: MAXPOOL_RELU_EN clamps negative maxima to zero.
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | waiting for start; pulses cnt_rst when start is taken
// WAIT_RD | counter address settles, memory read in flight
// CMP     | registers max of the three read words into max_q
// WRITE   | writes max_q at out_idx and pulses adv
// DONE    | one-cycle completion pulse
module maxpool3_stage
  import maxpool_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_OUT    = DEF_NUM_OUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] rd_data_1,
  input  logic signed [DATA_WIDTH-1:0] rd_data_2,
  input  logic signed [DATA_WIDTH-1:0] rd_data_3,
  output logic                         cnt_rst,
  output logic                         adv,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         busy,
  output logic                         done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_OUT - 1);

  state_t                        state;
  state_t                        state_nxt;
  logic [ADDR_WIDTH-1:0]         out_idx;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic signed [DATA_WIDTH-1:0]  max_q;
  logic signed [DATA_WIDTH-1:0]  max3;
  logic signed [DATA_WIDTH-1:0]  pool_val;

  max3_signed #(
    .W (DATA_WIDTH)
  ) u_max3 (
    .a (rd_data_1),
    .b (rd_data_2),
    .c (rd_data_3),
    .y (max3)
  );

  // Optional fused ReLU on the pooled value
  always_comb begin
    pool_val = max3;
`ifdef MAXPOOL_RELU_EN
    if (max3[DATA_WIDTH-1]) pool_val = '0;
`else
    pool_val = max3;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WAIT_RD;
      WAIT_RD: state_nxt = CMP;
      CMP:     state_nxt = WRITE;
      WRITE:   state_nxt = (out_idx == LAST_IDX) ? DONE : WAIT_RD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output index: cleared when a pass is accepted, stepped after each write
  always_ff @(posedge clk) begin
    if (rst) begin
      out_idx <= '0;
    end else if (state == IDLE && start) begin
      out_idx <= '0;
    end else if (state == WRITE && out_idx != LAST_IDX) begin
      out_idx <= out_idx + 1'b1;
    end
  end

  // Capture pooled value and its address in CMP; both hold outside WRITE
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q  <= '0;
      addr_q <= '0;
    end else if (state == CMP) begin
      max_q  <= pool_val;
      addr_q <= out_idx;
    end
  end

  // Strobes decoded from state
  always_comb begin
    cnt_rst = 1'b0;
    adv     = 1'b0;
    wr_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:    cnt_rst = start & ~rst;
      WAIT_RD: busy = 1'b1;
      CMP:     busy = 1'b1;
      WRITE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        adv   = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_addr = addr_q;
  assign wr_data = max_q;

endmodule : maxpool3_stage

// File: tb/tb_maxpool3_stage.sv
// Directed bench for maxpool3_stage with a triplet-counter and
// one-cycle-latency memory model driving the read ports.
module tb_maxpool3_stage;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NO = 169;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic signed [DW-1:0] rd_data_1, rd_data_2, rd_data_3;
  logic          cnt_rst, adv, wr_en, busy, done;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int errors = 0;
  int checks = 0;

  logic signed [DW-1:0] mem [0:511];
  int                   exp_data [0:NO-1];
  int                   cnt = 0;

  typedef struct {
    int a;
    int b;
    int c;
    int e_raw;
    int e_relu;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  maxpool3_stage #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_OUT    (NO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2),
    .rd_data_3 (rd_data_3),
    .cnt_rst   (cnt_rst),
    .adv       (adv),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Triplet counter plus three read ports with one cycle of latency
  always @(posedge clk) begin
    if (cnt_rst)  cnt <= 0;
    else if (adv) cnt <= cnt + 3;
    rd_data_1 <= mem[cnt];
    rd_data_2 <= mem[cnt + 1];
    rd_data_3 <= mem[cnt + 2];
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt_rst"}, int'(cnt_rst), 0);
    chk({tag, "_adv"},     int'(adv), 0);
    chk({tag, "_wr_en"},   int'(wr_en), 0);
    chk({tag, "_busy"},    int'(busy), 0);
    chk({tag, "_done"},    int'(done), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'($signed(wr_data)), 0);
  endtask

  // Entered #1 after a posedge; that cycle is C0. Returns in C509.
  task automatic run_pass(input bit hold);
    bit wexp;
    start = 1'b1;
    #1;
    chk("c0_cnt_rst", int'(cnt_rst), 1);
    for (int cyc = 1; cyc <= 509; cyc++) begin
      @(posedge clk); #1;
      wexp = (cyc >= 3) && (cyc <= 507) && ((cyc % 3) == 0);
      chk("wr_en", int'(wr_en), int'(wexp));
      chk("adv", int'(adv), int'(wexp));
      if (wexp) begin
        chk("wr_addr", int'(wr_addr), (cyc - 3) / 3);
        chk("wr_data", int'($signed(wr_data)), exp_data[(cyc - 3) / 3]);
      end
      chk("busy", int'(busy), int'(cyc <= 508));
      chk("done", int'(done), int'(cyc == 508));
      chk("cnt_rst", int'(cnt_rst), int'(hold && cyc == 509));
      if (!hold) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 512; i++) mem[i] = DW'(i);
    for (int k = 0; k < NO; k++) exp_data[k] = 3 * k + 2;
  endtask

  task automatic load_table();
    for (int i = 0; i < 512; i++) mem[i] = '0;
    for (int k = 0; k < NO; k++) exp_data[k] = 0;
    for (int v = 0; v < NV; v++) begin
      mem[3*v]     = DW'(vecs[v].a);
      mem[3*v + 1] = DW'(vecs[v].b);
      mem[3*v + 2] = DW'(vecs[v].c);
`ifdef MAXPOOL_RELU_EN
      exp_data[v] = vecs[v].e_relu;
`else
      exp_data[v] = vecs[v].e_raw;
`endif
    end
  endtask

  initial begin
    //           a       b       c       raw     relu
    vecs[0] = '{    -5,     -9,     -2,     -2,     0};
    vecs[1] = '{     7,      7,      3,      7,     7};
    vecs[2] = '{-32768,  32767,      0,  32767, 32767};
    vecs[3] = '{     1,      2,      3,      3,     3};
    vecs[4] = '{     3,      2,      1,      3,     3};
    vecs[5] = '{    -1,     -1,     -1,     -1,     0};
    vecs[6] = '{     0,     -1,      5,      5,     5};
    vecs[7] = '{-32768, -32768, -32767, -32767,     0};
    vecs[8] = '{   100,   -100,    100,    100,   100};

    rst   = 1'b1;
    start = 1'b0;
    load_ramp();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset: everything stays at zero
    for (int i = 0; i < 20; i++) begin
      chk_all_zero("idle");
      @(posedge clk); #1;
    end

    // Full pass over the ramp pattern
    run_pass(1'b0);
    @(posedge clk); #1;

    // Reset during CMP of output 50 (C152)
    start = 1'b1;
    for (int cyc = 1; cyc <= 152; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_wr_addr", int'(wr_addr), 49);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("post_rst");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_rst_wr_en", int'(wr_en), 0);
      chk("post_rst_busy", int'(busy), 0);
    end

    // Fresh pass after the abort restarts at address 0
    run_pass(1'b0);
    @(posedge clk); #1;

    // Table of hand-computed triplets
    load_table();
    run_pass(1'b0);
    @(posedge clk); #1;

    // start held high for a whole pass: only one pass, re-accepted at C509
    run_pass(1'b1);
    @(posedge clk); #1;
    chk("after_hold_busy", int'(busy), 0);
    chk("after_hold_cnt_rst", int'(cnt_rst), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_maxpool3_stage

// File: doc/maxpool3_stage.md
# maxpool3_stage

Downstream consumer of the triplet address counter in the max-pooling path. Reads three signed convolution results per step from the convolution-result memory and computes their maximum. Writes that maximum to the max-pool result memory at a sequential address. Tells the counter when to advance, and signals completion of a full pass to the SoC control logic.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of each signed convolution result and of each pooled result.
- `ADDR_WIDTH`, 10: width of the write address into the max-pool result memory.
- `NUM_OUT`, 169: pooled outputs per pass. Equals the convolution-result depth (507) divided by 3.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock; all state changes on the rising edge.
  - `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `rd_data_1`, `rd_data_2`, `rd_data_3`  in  DATA_WIDTH each  signed read data. Each memory read port has 1-cycle latency, addressed by counter outputs 1, 2 and 3.
- `cnt_rst`  out  1  one-cycle pulse that reinitialises the triplet counter to 0/1/2.
- `adv`  out  1  one-cycle pulse that steps the triplet counter by 3.
- `wr_en`  out  1  write strobe to the max-pool result memory.
- `wr_addr`  out  ADDR_WIDTH  write address, 0 to NUM_OUT-1.
- `wr_data`  out  DATA_WIDTH  pooled value.
- `busy`  out  1  high from the cycle after start is accepted until DONE is left.
- `done`  out  1  one-cycle pulse after the last write.

## Operation
- FSM states:
  - IDLE.
  - WAIT_RD: the counter address settles and the memory read is in flight.
  - CMP: registers the signed maximum of the three read-data inputs into `max_q`.
  - WRITE: drives `wr_en`=1, `wr_data`=`max_q`, `wr_addr`=`out_idx`, and `adv`=1.
  - DONE.
- Transitions:
  - IDLE goes to WAIT_RD on `start`, pulsing `cnt_rst` in the accepting cycle and clearing `out_idx`.
  - WAIT_RD goes to CMP.
  - CMP goes to WRITE.
  - WRITE goes to DONE if `out_idx`==NUM_OUT-1; otherwise it goes to WAIT_RD and increments `out_idx`.
  - DONE goes to IDLE.
- The comparison is signed two's complement. On ties the lower-numbered input wins (same value, deterministic selection).
- `adv` is also pulsed on the final WRITE, so the counter wraps consistently with its own end-of-pass logic.
- `start` is ignored outside IDLE.
- `rst` in any state:
  - Next state is IDLE.
  - `out_idx` and `max_q` are cleared.
  - All outputs are 0 from the following cycle. No partial write is issued.
- Reset values: `cnt_rst`, `adv`, `wr_en`, `busy` and `done` are 0; `wr_addr` and `wr_data` are 0.
- `wr_addr` and `wr_data` hold their last values outside WRITE. Consumers use `wr_en` only.

## Timing
- C0: `start` is sampled in IDLE; `cnt_rst`=1.
- C1: WAIT_RD.
- C2: CMP samples `rd_data_*` for addresses 0/1/2.
- C3: first WRITE, with `wr_addr`=0.
- Steady state is 3 cycles per output: output k is written in cycle C3+3k.
- The last write (k=168) is in C507. `done`=1 in C508. IDLE is reached in C509, where a new `start` can be accepted.
- `busy`=1 for C1 through C508.
- The read data consumed in CMP corresponds to the counter value presented two cycles earlier: one cycle for the counter update and one for memory latency.

## Configuration
- `MAXPOOL_RELU_EN` defined: CMP registers max(max3, 0), so any negative maximum is written as 0. This fuses ReLU into the stage.
- Macro undefined: the raw signed maximum is written unchanged.
- Cycle timing is identical in both builds.

## Structure
- Shared package `maxpool_pkg`:
  - The FSM state enum (IDLE, WAIT_RD, CMP, WRITE, DONE).
  - Default width constants: DATA_WIDTH 16, ADDR_WIDTH 10.
  - Default NUM_OUT 169.
- One combinational sub-module, `max3_signed`, computes the signed maximum of three values with lowest-index tie-break. It is instantiated once and feeds `max_q`.
- The FSM, `out_idx` and the output registers live in the top module.

## Test plan
- Reset then idle, no `start`:
  - All outputs stay 0 for 20 cycles.
- `start` with memory word i = i for 0..506:
  - The 169 writes produce `wr_data`=3k+2 at `wr_addr`=k, each in cycle C3+3k.
  - `done` pulses once, in C508.
- Triplet (-5, -9, -2):
  - Without the macro, the write is -2.
  - With `MAXPOOL_RELU_EN`, the write is 0.
- Triplets (7, 7, 3) and (-32768, 32767, 0):
  - The writes are 7 and 32767 (signed compare, no overflow).
- `rst` asserted in CMP of output 50:
  - No write occurs for index 50.
  - `busy`=0 on the next cycle.
  - A fresh `start` restarts at `wr_addr`=0 with a `cnt_rst` pulse.
- `start` held high during a pass and in DONE:
  - Exactly one pass runs.
  - A new pass begins only when `start` is seen in IDLE (C509 or later).
